kbd_cmd_scheduler: RTL and testbench

- Arbitrates the six direction signals from the PS2 keyboard decoder (forward, backward, left, right, up, down) and turns them into a stream of 3-bit direction commands.
- Edge-detects key presses, holds one pending request per key, and grants at most one request per cycle in fixed priority into a command FIFO.
- The FIFO is drained by the CPU I/O side through a valid/ready handshake.
- Sits between the keyboard decoder and the pipeline's I/O port, replacing the decoder-clocked direction register.

---
 rtl/kbd_cmd_scheduler.sv | 108 ++++++++++
 tb/tb_kbd_cmd_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_scheduler.sv
// kbd_cmd_scheduler: edge-detects six direction keys, arbitrates pending requests into a command FIFO.
// Define KBD_AUTOREPEAT_EN to enable typematic repeat of the highest-priority held key.
module kbd_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic forward,
  input  logic backward,
  input  logic left,
  input  logic right,
  input  logic up,
  input  logic down,
  output logic cmd_valid,
  output logic [2:0] cmd_code,
  input  logic cmd_ready,
  output logic [2:0] state,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [5:0] keys, prev, pend, rise, gnt, taken, rep_set;
  logic [2:0] gcode, code_n;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] rem, cnt_n;
  logic pop, push;
  assign keys = {down, up, right, left, backward, forward};
  assign rise = keys & ~prev;
  assign pop = cmd_valid && cmd_ready;
  assign taken = push ? gnt : '0;
  always_comb begin
    gnt = '0;
    gcode = '0;
    for (int i = 5; i >= 0; i--) begin
      if (pend[i]) begin
        gnt = 6'(1) << i;
        gcode = 3'(i);
      end
    end
    push = |gnt && (fifo_count != (AW+1)'(DEPTH) || pop);
    rem = fifo_count - (AW+1)'(pop);
    cnt_n = rem + (AW+1)'(push);
    // head after this edge: freshly pushed entry if the queue would otherwise be empty
    code_n = (rem == '0) ? (push ? gcode : cmd_code) : mem[rd_ptr + AW'(pop)];
  end
  always_ff @(posedge CLK) begin
    if (push && !RST) mem[wr_ptr] <= gcode;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev <= '0;
      pend <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      cmd_valid <= 1'b0;
      cmd_code <= 3'b000;
      state <= 3'b001;
      overflow <= 1'b0;
    end else begin
      prev <= keys;
      pend <= (pend & ~taken) | rise | rep_set;
      overflow <= overflow | |(rise & pend & ~taken);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        state <= cmd_code;
      end
      fifo_count <= cnt_n;
      cmd_valid <= cnt_n != '0;
      cmd_code <= code_n;
    end
  end
`ifdef KBD_AUTOREPEAT_EN
  logic [5:0] tgt, tgt_n;
  logic [31:0] rcnt;
  logic rphase, fire;
  always_comb begin
    tgt_n = keys & (~keys + 6'd1);
    fire = tgt_n != '0 && tgt_n == tgt &&
           rcnt == (rphase ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1));
    rep_set = fire ? tgt_n : '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tgt <= '0;
      rcnt <= '0;
      rphase <= 1'b0;
    end else begin
      tgt <= tgt_n;
      if (tgt_n == '0 || tgt_n != tgt) begin
        rcnt <= '0;
        rphase <= 1'b0;
      end else if (fire) begin
        rcnt <= '0;
        rphase <= 1'b1;
      end else begin
        rcnt <= rcnt + 32'd1;
      end
    end
  end
`else
  assign rep_set = '0;
`endif
endmodule

// File: tb/tb_kbd_cmd_scheduler.sv
// tb_kbd_cmd_scheduler: directed scenarios plus randomized key/ready traffic against a queue-based model.
module tb_kbd_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int DLY = 8;
  localparam int PER = 4;
  logic CLK = 0, RST = 1, cmd_ready = 0;
  logic [5:0] k = '0;
  logic cmd_valid, overflow;
  logic [2:0] cmd_code, state;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  int got[$];
  int mq[$];
  bit [5:0] mpend, mprev;
  bit [2:0] mstate;
  bit movf;
  int mtgt, mage;

  kbd_cmd_scheduler #(.DEPTH(DEPTH), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
    .CLK(CLK), .RST(RST),
    .forward(k[0]), .backward(k[1]), .left(k[2]), .right(k[3]), .up(k[4]), .down(k[5]),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
    .state(state), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // reference: pending set + ordered queue, evaluated from the key/ready levels at each edge
  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      mpend = '0;
      mprev = '0;
      mstate = 3'b001;
      movf = 0;
      mtgt = -1;
      mage = 0;
    end else begin
      int n0, g, t;
      bit popd;
      n0 = mq.size();
      popd = n0 > 0 && cmd_ready;
      if (popd) begin
        mstate = 3'(mq[0]);
        void'(mq.pop_front());
      end
      g = -1;
      for (int i = 5; i >= 0; i--) if (mpend[i]) g = i;
      if (g >= 0 && (n0 < DEPTH || popd)) begin
        mq.push_back(g);
        mpend[g] = 0;
      end
      for (int i = 0; i < 6; i++)
        if (k[i] && !mprev[i]) begin
          if (mpend[i]) movf = 1;
          mpend[i] = 1;
        end
`ifdef KBD_AUTOREPEAT_EN
      t = -1;
      for (int i = 5; i >= 0; i--) if (k[i]) t = i;
      if (t < 0 || t != mtgt) mage = 0;
      else mage++;
      mtgt = t;
      if (t >= 0 && mage >= DLY && (mage - DLY) % PER == 0) mpend[t] = 1;
`else
      t = 0;
`endif
      mprev = k;
    end
  end

  task automatic do_reset();
    RST = 1;
    k = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      k = 6'(1) << i;
      @(negedge CLK);
    end
    k = '0;
  endtask

  task automatic collect(input int n);
    got.delete();
    repeat (n) begin
      if (cmd_valid) got.push_back(int'(cmd_code));
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_code !== 3'b000 || state !== 3'b001 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b code=%b state=%b count=%0d ovf=%b, need 0 000 001 0 0",
               cmd_valid, cmd_code, state, fifo_count, overflow);
    end
  endtask

  task automatic test_single_press();
    cmd_ready = 1;
    k = 6'b000100;
    @(negedge CLK);
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL single_early: valid=%b need 0", cmd_valid); end
    @(negedge CLK);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'b010 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_push: valid=%b code=%b count=%0d need 1 010 1", cmd_valid, cmd_code, fifo_count);
    end
    @(negedge CLK);
    checks++;
    if (cmd_valid !== 1'b0 || state !== 3'b010 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL single_pop: valid=%b state=%b count=%0d need 0 010 0", cmd_valid, state, fifo_count);
    end
    k = '0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_simultaneous();
    int exp[3] = '{0, 3, 4};
    cmd_ready = 1;
    k = 6'b011001;
    @(negedge CLK);
    k = '0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || int'(cmd_code) != exp[i]) begin
        failures++;
        $display("FAIL simul_seq%0d: valid=%b code=%0d need 1 %0d", i, cmd_valid, cmd_code, exp[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if (cmd_valid !== 1'b0 || state !== 3'b100 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL simul_end: valid=%b state=%b ovf=%b need 0 100 0", cmd_valid, state, overflow);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    cmd_ready = 0;
    pulses(6);
    repeat (3) @(negedge CLK);
    checks++;
    if (fifo_count !== 3'd4 || cmd_valid !== 1'b1 || cmd_code !== 3'b000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_stall: count=%0d valid=%b code=%b ovf=%b need 4 1 000 0", fifo_count, cmd_valid, cmd_code, overflow);
    end
    cmd_ready = 1;
    collect(12);
    checks++;
    if (got.size() != 6) begin
      failures++;
      $display("FAIL full_drain_len: got %0d commands need 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] != i) begin failures++; $display("FAIL full_drain%0d: code=%0d need %0d", i, got[i], i); end
    end
    checks++;
    if (state !== 3'b101 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL full_state: state=%b count=%0d need 101 0", state, fifo_count);
    end
  endtask

  task automatic test_overflow();
    int ups;
    do_reset();
    cmd_ready = 0;
    pulses(4);
    k = 6'b010000;
    @(negedge CLK);
    k = '0;
    @(negedge CLK);
    k = 6'b010000;
    @(negedge CLK);
    k = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: ovf=%b need 1", overflow); end
    cmd_ready = 1;
    collect(10);
    ups = 0;
    foreach (got[i]) if (got[i] == 4) ups++;
    checks++;
    if (ups != 1 || got.size() != 5) begin
      failures++;
      $display("FAIL ovf_drain: up_count=%0d total=%0d need 1 5", ups, got.size());
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: ovf=%b need 1", overflow); end
  endtask

  task automatic test_mid_reset();
    cmd_ready = 0;
    pulses(3);
    repeat (3) @(negedge CLK);
    checks++;
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL midrst_fill: count=%0d need 3", fifo_count); end
    RST = 1;
    @(negedge CLK);
    checks++;
    if (cmd_valid !== 1'b0 || fifo_count !== 3'd0 || state !== 3'b001 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midrst: valid=%b count=%0d state=%b ovf=%b need 0 0 001 0", cmd_valid, fifo_count, state, overflow);
    end
    RST = 0;
    @(negedge CLK);
  endtask

  task automatic test_autorepeat();
    int n, expn;
`ifdef KBD_AUTOREPEAT_EN
    expn = 4;
`else
    expn = 1;
`endif
    do_reset();
    cmd_ready = 1;
    n = 0;
    k = 6'b100000;
    repeat (20) begin
      @(negedge CLK);
      if (cmd_valid && cmd_code == 3'b101) n++;
    end
    k = '0;
    repeat (6) begin
      @(negedge CLK);
      if (cmd_valid && cmd_code == 3'b101) n++;
    end
    checks++;
    if (n != expn) begin failures++; $display("FAIL autorepeat: down_cmds=%0d need %0d", n, expn); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (cmd_valid !== (mq.size() > 0) || fifo_count !== 3'(mq.size()) || state !== mstate ||
          overflow !== movf || (mq.size() > 0 && int'(cmd_code) != mq[0])) begin
        failures++;
        if (bad++ < 5)
          $display("FAIL random@%0d: valid=%b code=%0d count=%0d state=%0d ovf=%b need %b %0d %0d %0d %b",
                   c, cmd_valid, cmd_code, fifo_count, state, overflow, mq.size() > 0,
                   mq.size() > 0 ? mq[0] : 0, mq.size(), mstate, movf);
      end
      for (int i = 0; i < 6; i++) if ($urandom_range(7) == 0) k[i] = ~k[i];
      cmd_ready = $urandom_range(1);
      if (c == 300) RST = 1;
      else RST = 0;
      @(negedge CLK);
    end
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_fifo_full();
    test_overflow();
    test_mid_reset();
    test_autorepeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
